// File: rtl/csi_packet_sequencer.sv
// CSI-2 packet sequencer: parses sync/header bytes from one byte-aligned lane,
// tracks frame state and forwards RAW10 line payload to the unpacker.
module csi_packet_sequencer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hB8,
  parameter logic [5:0]  DT_RAW10  = 6'h2B,
  parameter logic [15:0] MAX_WC    = 16'd4000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic [1:0]  vc_sel_i,
  output logic [7:0]  pay_data_o,
  output logic        pay_valid_o,
  output logic        pay_first_o,
  output logic        pay_last_o,
  output logic        fsync_o,
  output logic        lsync_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] line_count_o,
  output logic [2:0]  err_o,
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_DROP    = 3'd3;
  localparam logic [2:0] S_CRC     = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_hdr_cnt;
  logic [7:0]  r_di;
  logic [15:0] r_wc;
  logic [15:0] r_cnt;
  logic        r_crc_cnt;
  logic [7:0]  r_pay_data;
  logic        r_pay_valid, r_pay_first, r_pay_last;
  logic        r_fsync, r_lsync, r_fs, r_fe;
  logic [15:0] r_line_cnt;
  logic [2:0]  r_err;

  logic [1:0] w_vc;
  logic [5:0] w_dt;
  logic       w_vc_ok, w_short, w_raw, w_wc_ok, w_accept;
  logic       w_ecc, w_is_fs, w_is_fe, w_trunc;
  logic [2:0] w_err_set;

  // Header decode is evaluated while the ECC byte is on the bus; DI and WC are already held.
  assign w_vc     = r_di[7:6];
  assign w_dt     = r_di[5:0];
  assign w_vc_ok  = (w_vc == vc_sel_i);
  assign w_short  = (w_dt < 6'h10);
  assign w_raw    = w_vc_ok && (w_dt == DT_RAW10);
  assign w_wc_ok  = (r_wc != 16'd0) && ((r_wc % 16'd5) == 16'd0) && (r_wc <= MAX_WC);
  assign w_accept = w_raw && r_fsync && w_wc_ok;
  assign w_ecc    = (r_state == S_HDR) && byte_valid_i && (r_hdr_cnt == 2'd3);
  assign w_is_fs  = w_ecc && w_short && w_vc_ok && (w_dt == 6'h00);
  assign w_is_fe  = w_ecc && w_short && w_vc_ok && (w_dt == 6'h01);
  assign w_trunc  = (r_state != S_IDLE) && !byte_valid_i;

  assign w_err_set[0] = w_ecc && !w_short && w_raw && !w_wc_ok;
  assign w_err_set[1] = w_trunc;
  assign w_err_set[2] = (w_is_fs && r_fsync) || (w_is_fe && !r_fsync) ||
                        (w_ecc && !w_short && w_raw && !r_fsync);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_hdr_cnt   <= 2'd0;
      r_di        <= 8'd0;
      r_wc        <= 16'd0;
      r_cnt       <= 16'd0;
      r_crc_cnt   <= 1'b0;
      r_pay_data  <= 8'd0;
      r_pay_valid <= 1'b0;
      r_pay_first <= 1'b0;
      r_pay_last  <= 1'b0;
      r_fsync     <= 1'b0;
      r_lsync     <= 1'b0;
      r_fs        <= 1'b0;
      r_fe        <= 1'b0;
      r_line_cnt  <= 16'd0;
      r_err       <= 3'd0;
    end else begin
      r_fs        <= 1'b0;
      r_fe        <= 1'b0;
      r_pay_valid <= 1'b0;
      r_pay_first <= 1'b0;
      r_pay_last  <= 1'b0;
      r_lsync     <= 1'b0;
      // FS clears the sticky flags, but a flag raised in the same cycle survives.
      r_err <= (w_is_fs ? 3'd0 : r_err) | w_err_set;
      if (r_pay_last && (r_line_cnt != 16'hFFFF))
        r_line_cnt <= r_line_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (byte_valid_i && enable_i && (byte_i == SYNC_BYTE)) begin
            r_state   <= S_HDR;
            r_hdr_cnt <= 2'd0;
          end
        end
        S_HDR: begin
          if (!byte_valid_i) begin
            r_state <= S_IDLE;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd0: r_di       <= byte_i;
              2'd1: r_wc[7:0]  <= byte_i;
              2'd2: r_wc[15:8] <= byte_i;
              default: begin
                if (w_short) begin
                  r_state <= S_IDLE;
                  if (w_is_fs) begin
                    r_fs       <= 1'b1;
                    r_fsync    <= 1'b1;
                    r_line_cnt <= 16'd0;
                  end
                  if (w_is_fe && r_fsync) begin
                    r_fe    <= 1'b1;
                    r_fsync <= 1'b0;
                  end
                end else begin
                  r_cnt     <= r_wc;
                  r_crc_cnt <= 1'b0;
                  if (w_accept)              r_state <= S_PAYLOAD;
                  else if (r_wc == 16'd0)    r_state <= S_CRC;
                  else                       r_state <= S_DROP;
                end
              end
            endcase
          end
        end
        S_PAYLOAD: begin
          if (!byte_valid_i) begin
            r_state <= S_IDLE;
          end else begin
            r_pay_data  <= byte_i;
            r_pay_valid <= 1'b1;
            r_pay_first <= (r_cnt == r_wc);
            r_pay_last  <= (r_cnt == 16'd1);
            r_lsync     <= 1'b1;
            r_cnt       <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_state <= S_CRC;
          end
        end
        S_DROP: begin
          if (!byte_valid_i) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_state <= S_CRC;
          end
        end
        S_CRC: begin
          if (!byte_valid_i)  r_state   <= S_IDLE;
          else if (r_crc_cnt) r_state   <= S_IDLE;
          else                r_crc_cnt <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pay_data_o    = r_pay_data;
  assign pay_valid_o   = r_pay_valid;
  assign pay_first_o   = r_pay_first;
  assign pay_last_o    = r_pay_last;
  assign fsync_o       = r_fsync;
  assign lsync_o       = r_lsync;
  assign frame_start_o = r_fs;
  assign frame_end_o   = r_fe;
  assign line_count_o  = r_line_cnt;
  assign err_o         = r_err;
  assign state_o       = r_state;

endmodule

// File: doc/csi_packet_sequencer.md
CSI_PACKET_SEQUENCER -- requirements
Module: csi_packet_sequencer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hB8: D-PHY leader/sync byte preceding every packet.
REQ-002 SHALL have parameter DT_RAW10, default 6'h2B: the only long-packet data type forwarded to the RAW10 unpacker.
REQ-003 SHALL have parameter MAX_WC, default 16'd4000: largest accepted long-packet word count in bytes.
REQ-004 SHALL have port wb_clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable_i, input, 1: allow new packet acquisition.
REQ-007 SHALL have port byte_i, input, 8: byte-aligned lane byte.
REQ-008 SHALL have port byte_valid_i, input, 1: byte_i valid this cycle; low means LP state or end of transmission.
REQ-009 SHALL have port vc_sel_i, input, 2: accepted virtual channel.
REQ-010 SHALL have ports pay_data_o (output, 8), pay_valid_o, pay_first_o and pay_last_o (outputs, 1 each): payload byte stream to the RAW10 unpacker.
REQ-011 SHALL have ports fsync_o and lsync_o, outputs, 1 each: frame-active and line-payload-active levels.
REQ-012 SHALL have ports frame_start_o and frame_end_o, outputs, 1 each: single-cycle pulses.
REQ-013 SHALL have port line_count_o, output, 16: RAW10 lines completed in the current frame.
REQ-014 SHALL have port err_o, output, 3: [0] word-count, [1] truncation, [2] sequence; all sticky.
REQ-015 SHALL have port state_o, output, 3: current FSM state, for debug.

Function
REQ-016 SHALL implement states IDLE=0, HDR=1, PAYLOAD=2, DROP=3, CRC=4.
REQ-017 IDLE -> HDR on byte_valid_i & enable_i & byte_i==SYNC_BYTE; otherwise stay in IDLE and ignore the byte.
REQ-018 enable_i SHALL be sampled only in IDLE; a packet already in progress SHALL complete regardless of enable_i.
REQ-019 HDR SHALL capture 4 bytes in order: DI (VC=DI[7:6], DT=DI[5:0]), WC[7:0], WC[15:8], ECC; ECC is not checked.
REQ-020 Short packet (DT<6'h10): after the ECC byte, return to IDLE; no payload and no CRC bytes follow.
REQ-021 Short packet with matching VC, DT=0x00 (FS): pulse frame_start_o, set fsync_o, clear line_count_o, clear err_o.
REQ-022 Short packet with matching VC, DT=0x01 (FE): pulse frame_end_o, clear fsync_o.
REQ-023 All other short packets, and all short packets with non-matching VC, SHALL be ignored.
REQ-024 FS received while fsync_o is high SHALL set err_o[2] and otherwise behave as REQ-021.
REQ-025 FE received while fsync_o is low SHALL set err_o[2] and produce no frame_end_o pulse.
REQ-026 Long packet (DT>=6'h10) -> PAYLOAD only if all hold: VC matches, DT==DT_RAW10, fsync_o=1, WC!=0, WC%5==0, WC<=MAX_WC.
REQ-027 A long packet failing REQ-026 SHALL go to DROP.
REQ-028 DROP caused by a WC rule failure on a matching-VC RAW10 packet SHALL set err_o[0].
REQ-029 DROP caused by fsync_o=0 on a matching-VC RAW10 packet SHALL set err_o[2].
REQ-030 DROP caused by VC or DT mismatch SHALL be silent.
REQ-031 PAYLOAD/DROP SHALL consume exactly WC valid bytes using a 16-bit down-counter, then go to CRC.
REQ-032 CRC SHALL consume exactly 2 valid bytes (CRC is not checked), then go to IDLE.
REQ-033 In PAYLOAD, each accepted byte SHALL appear on pay_data_o with pay_valid_o=1 exactly one cycle later (registered).
REQ-034 pay_first_o SHALL accompany the first payload byte and pay_last_o the WC-th payload byte.
REQ-035 lsync_o SHALL be high from the cycle of the first pay_valid_o through the cycle of pay_last_o inclusive.
REQ-036 line_count_o SHALL increment in the cycle after pay_last_o and saturate at 16'hFFFF.
REQ-037 byte_valid_i=0 while in HDR, PAYLOAD, DROP or CRC SHALL set err_o[1] and go to IDLE next cycle.
REQ-038 On such a truncation, lsync_o SHALL deassert, pay_last_o SHALL NOT assert, and line_count_o SHALL be unchanged.
REQ-039 frame_start_o/frame_end_o SHALL assert one cycle after the ECC byte is accepted.
REQ-040 When an error set and the FS clear of err_o fall in the same cycle, the set SHALL win.

Reset
REQ-041 On wb_rst_i=1 at a clock edge, state=IDLE and every output SHALL be 0 (including err_o, line_count_o, fsync_o, lsync_o); counters and header registers cleared.
REQ-042 Reset SHALL override any packet in progress, with no pay_last_o and no frame_end_o pulse.

Verification
REQ-043 Reset asserted mid-PAYLOAD -> next cycle: state_o=0, pay_valid_o=0, fsync_o=0, err_o=0, line_count_o=0.
REQ-044 vc_sel_i=0; stream B8,00,00,00,xx / B8,2B,05,00,xx,5 bytes,2 CRC / B8,01,00,00,xx -> one frame_start_o, 5 pay_valid_o with first/last, line_count_o=1, one frame_end_o, err_o=0.
REQ-045 RAW10 long packet with WC=6 inside a frame -> err_o=3'b001, no pay_valid_o, 8 bytes consumed, IDLE after; next packet parsed normally.
REQ-046 byte_valid_i low after 2 payload bytes of a WC=10 packet -> err_o[1]=1, lsync_o=0, no pay_last_o, line_count_o unchanged, IDLE; next B8 accepted.
REQ-047 RAW10 packet with DI=8'h6B while vc_sel_i=0 -> silently dropped, err_o=0; RAW10 packet before any FS -> err_o[2]=1, no pay_valid_o.
REQ-048 Two FS packets without an FE between them -> two frame_start_o pulses, err_o[2]=1, line_count_o=0 after the second FS.
